// File: rtl/switch_conditioner.sv
// Slide-switch input conditioner: two-flop synchroniser, per-bit debounce,
// handshake-bit edge pulses and a latched data word with valid/ack.
module switch_conditioner #(
  parameter int W               = 10,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HS_BIT          = 8,
  parameter int D_SIZE          = 8
) (
  input  logic              clk,
  input  logic              nRst,
  input  logic [W-1:0]      switchesRaw,
  output logic [W-1:0]      switchesOut,
  output logic              hsRise,
  output logic              hsFall,
  output logic [D_SIZE-1:0] dataOut,
  output logic              dataValid,
  input  logic              dataAck
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [W-1:0]  sync1;
  logic [W-1:0]  sync2;
  logic [W-1:0]  stable_next;
  logic [CW-1:0] cnt      [W];
  logic [CW-1:0] cnt_next [W];
  logic          hs_rise_next;
  logic          hs_fall_next;

  // The next stable vector is formed combinationally so the data latch can
  // capture bits that settle on the same edge as the handshake bit.
  always_comb begin
    stable_next = switchesOut;
    for (int unsigned i = 0; i < W; i++) begin
      cnt_next[i] = '0;
      if (sync2[i] != switchesOut[i]) begin
        if (cnt[i] == CNT_LAST) begin
          stable_next[i] = sync2[i];
        end else begin
          cnt_next[i] = cnt[i] + 1'b1;
        end
      end
    end
    hs_rise_next = stable_next[HS_BIT] & ~switchesOut[HS_BIT];
    hs_fall_next = ~stable_next[HS_BIT] & switchesOut[HS_BIT];
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      sync1       <= '0;
      sync2       <= '0;
      switchesOut <= '0;
      hsRise      <= 1'b0;
      hsFall      <= 1'b0;
      dataOut     <= '0;
      dataValid   <= 1'b0;
      for (int unsigned i = 0; i < W; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1       <= switchesRaw;
      sync2       <= sync1;
      switchesOut <= stable_next;
      hsRise      <= hs_rise_next;
      hsFall      <= hs_fall_next;
      for (int unsigned i = 0; i < W; i++) begin
        cnt[i] <= cnt_next[i];
      end
      // A new rise takes priority over a same-cycle acknowledge.
      if (hs_rise_next) begin
        dataOut   <= stable_next[D_SIZE-1:0];
        dataValid <= 1'b1;
      end else if (hs_fall_next) begin
        dataValid <= 1'b0;
      end else if (dataAck && dataValid) begin
        dataValid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/switch_conditioner.md
Name: switch_conditioner

Overview:
- Input-conditioning stage directly upstream of the CPU top-level `switchesIn` port.
- Takes the raw, asynchronous board slide switches and makes them safe to use inside the CPU:
  - synchronises them to `clk`;
  - debounces each bit independently;
  - produces a clean 10-bit switch vector.
- Also derives edge pulses and a latched-data handshake from a designated handshake switch, for program-level input polling.

Parameters:
- W, 10, switch vector width.
- DEBOUNCE_CYCLES, 4, consecutive mismatch cycles required before a stable bit changes; legal range ≥ 1.
- HS_BIT, 8, index of the handshake switch; legal range 0..W-1.
- D_SIZE, 8, width of the latched data field, taken from switch bits [D_SIZE-1:0]; must be ≤ W.

Ports:
- clk  in  1  system clock
- nRst  in  1  asynchronous active-low reset
- switchesRaw  in  W  raw board switches, asynchronous to clk
- switchesOut  out  W  synchronised, debounced switch vector (feeds CPU switchesIn)
- hsRise  out  1  one-cycle pulse: stable handshake bit went 0→1
- hsFall  out  1  one-cycle pulse: stable handshake bit went 1→0
- dataOut  out  D_SIZE  switch data captured on hsRise
- dataValid  out  1  dataOut holds unconsumed data
- dataAck  in  1  consumer acknowledge; tie 0 if unused

Behaviour:
- Reset (nRst low, asynchronous): every register clears immediately. This covers sync flops, counters, switchesOut, hsRise, hsFall, dataOut and dataValid, which all go to 0. Reset mid-debounce discards any count in progress.
- Synchroniser: two flops per bit, s1 <= switchesRaw, s2 <= s1. No logic between s1 and s2.
- Debounce, per bit i, counter width $clog2(DEBOUNCE_CYCLES+1):
  - s2[i] == switchesOut[i]: counter <= 0.
  - mismatch and counter == DEBOUNCE_CYCLES-1: switchesOut[i] <= s2[i], counter <= 0.
  - mismatch otherwise: counter <= counter+1.
  - A glitch shorter than DEBOUNCE_CYCLES sampled cycles never reaches switchesOut. Any return to match restarts the count from 0.
  - Counters never exceed DEBOUNCE_CYCLES-1 (no wrap-around).
- Latency: a clean raw change that is stable before edge k appears on switchesOut after edge k+1+DEBOUNCE_CYCLES. That is 2+DEBOUNCE_CYCLES cycles.
- Edge pulses:
  - hsRise is registered. It is high for exactly the one cycle in which switchesOut[HS_BIT] has just become 1; hsFall is the same for the change to 0.
  - hsRise and hsFall are never high together. A new pulse cannot occur within DEBOUNCE_CYCLES cycles of the previous one.
- Data latch:
  - On the same edge that switchesOut[HS_BIT] updates 0→1, dataOut <= debounced value of bits [D_SIZE-1:0], taking any simultaneous update of those bits. dataValid <= 1 on that edge.
  - dataAck high while dataValid high: dataValid <= 0 next edge. dataOut is held.
  - Handshake fall: dataValid <= 0.
  - Simultaneous rise and ack (possible only if the consumer acks early): the rise wins, so dataValid stays 1 and dataOut is reloaded.
  - Rise while dataValid is already 1: overwrite dataOut, dataValid stays 1.
  - dataAck while dataValid is 0: ignored.
- If HS_BIT lies inside [D_SIZE-1:0], the captured value of that bit is 1.
- No combinational path from any input to any output.

Test Plan:
- Reset: drive switchesRaw=10'h3FF and assert nRst mid-run → all outputs are 0 immediately, asynchronously. After release, switchesOut=10'h3FF exactly 2+4=6 edges later.
- Debounce: switchesRaw[3] toggles 1 for 3 cycles then back to 0 → switchesOut stays 10'h000. Then hold it at 1 for ≥6 cycles → switchesOut[3]=1 at edge 6 after the change.
- Bounce restart: switchesRaw[0] pattern 1,1,1,0,1,1,1,1 → switchesOut[0] changes only 4 cycles after the final 0→1 (plus 2 sync cycles).
- Handshake capture: set switchesRaw[7:0]=8'hA5, wait 10 cycles, then set bit 8 → single-cycle hsRise, dataOut=8'hA5 and dataValid=1 on the same edge. Pulse dataAck → dataValid=0 next edge with dataOut still 8'hA5. Clear bit 8 → single hsFall.
- Fall clears valid: capture 8'h3C and never ack, then clear bit 8 → dataValid=0 on the hsFall edge.
- Overwrite: capture 8'h11, leave unacked, cycle bit 8 low then high with data 8'h22 → dataOut=8'h22, dataValid=1 throughout the second rise.
